// File: rtl/ad9958_spi_responder.sv
// AD9958 serial-port responder: deserializes sclk/cs_n/sdio frames into
// buffer registers and transfers them to active outputs on io_update.
module ad9958_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CSR_RESET   = 8'hF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic [3:0]  sdio,
    input  logic        io_update,
    input  logic        master_reset,
    output logic [31:0] ftw_ch0,
    output logic [31:0] ftw_ch1,
    output logic [9:0]  asf_ch0,
    output logic [9:0]  asf_ch1,
    output logic [1:0]  asf_en,
    output logic [3:0]  dac_fscale,
    output logic        vco_gain,
    output logic [4:0]  pll_mult,
    output logic [7:0]  csr,
    output logic        write_strobe,
    output logic [4:0]  last_addr,
    output logic        frame_error
);
    typedef enum logic [1:0] {IDLE, INSTR, DATA, SKIP} state_t;

    typedef struct packed {
        logic [31:0] ftw0;
        logic [31:0] ftw1;
        logic [9:0]  asf0;
        logic [9:0]  asf1;
        logic [1:0]  asf_en;
        logic [3:0]  dac;
        logic        vco;
        logic [4:0]  pll;
    } regs_t;

    // cs_n idles high so its synchronizer starts high
    localparam logic [7:0] PIN_INIT = 8'b0000_0010;

    logic [7:0]  pins;
    logic [7:0]  sync_q [SYNC_STAGES];
    logic [7:0]  pin_s;
    logic        sclk_d, iou_d;
    logic        sclk_rise, iou_rise, cs_hi, mr;
    logic [3:0]  s_data;

    state_t      state, state_n;
    logic [2:0]  bit_cnt;
    logic [3:0]  bpe, cnt_sum;
    logic        four, byte_done, instr_bad, last_byte;
    logic [31:0] shifter, shift_n;
    logic [4:0]  addr, commit_addr;
    logic [2:0]  bytes_left;
    logic        commit_req, err_p, commit_p;
    regs_t       buf_q, act_q;

    function automatic logic [2:0] reg_size(input logic [4:0] a);
        case (a)
            5'd0:    reg_size = 3'd1;
            5'd1:    reg_size = 3'd3;
            5'd2:    reg_size = 3'd2;
            5'd3:    reg_size = 3'd3;
            5'd4:    reg_size = 3'd4;
            5'd5:    reg_size = 3'd2;
            5'd6:    reg_size = 3'd3;
            default: reg_size = 3'd0;
        endcase
    endfunction

    assign pins = {master_reset, io_update, sdio, cs_n, sclk};
    assign pin_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_INIT;
            sclk_d <= 1'b0;
            iou_d  <= 1'b0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_d <= pin_s[0];
            iou_d  <= pin_s[6];
        end
    end

    assign sclk_rise = pin_s[0] & ~sclk_d;
    assign iou_rise  = pin_s[6] & ~iou_d;
    assign cs_hi     = pin_s[1];
    assign s_data    = pin_s[5:2];
    assign mr        = pin_s[7];

    assign four      = (csr[2:1] == 2'b11);
    assign bpe       = four ? 4'd4 : 4'd1;
    assign cnt_sum   = {1'b0, bit_cnt} + bpe;
    assign byte_done = sclk_rise & cnt_sum[3] & ~cs_hi;
    assign shift_n   = four ? {shifter[27:0], s_data}
                            : {shifter[30:0], s_data[0]};
    assign instr_bad = shift_n[7] | (reg_size(shift_n[4:0]) == 3'd0);
    assign last_byte = (bytes_left == 3'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)   state <= IDLE;
        else if (mr) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (!cs_hi) state_n = csr[0] ? SKIP : INSTR;
            INSTR: if (cs_hi) state_n = IDLE;
                   else if (byte_done) state_n = instr_bad ? SKIP : DATA;
            DATA:  if (cs_hi) state_n = IDLE;
                   else if (byte_done && last_byte) state_n = INSTR;
            SKIP:  if (cs_hi) state_n = IDLE;
        endcase
    end

    always_comb begin
        err_p    = 1'b0;
        commit_p = 1'b0;
        unique case (state)
            IDLE:  err_p = ~cs_hi & csr[0];
            INSTR: if (cs_hi) err_p = (bit_cnt != 3'd0);
                   else err_p = byte_done & instr_bad;
            DATA:  if (cs_hi) err_p = 1'b1;
                   else commit_p = byte_done & last_byte;
            SKIP:  err_p = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0; shifter <= '0; addr <= '0; bytes_left <= '0;
            commit_req <= 1'b0; commit_addr <= '0; write_strobe <= 1'b0;
            last_addr <= '0; frame_error <= 1'b0; csr <= CSR_RESET;
            buf_q <= '0; act_q <= '0;
        end else if (mr) begin
            bit_cnt <= '0; shifter <= '0; addr <= '0; bytes_left <= '0;
            commit_req <= 1'b0; commit_addr <= '0; write_strobe <= 1'b0;
            last_addr <= '0; frame_error <= 1'b0; csr <= CSR_RESET;
            buf_q <= '0; act_q <= '0;
        end else begin
            frame_error  <= err_p;
            commit_req   <= commit_p;
            commit_addr  <= addr;
            write_strobe <= commit_req;
            if (state == IDLE || cs_hi) begin
                bit_cnt <= '0;
            end else if (sclk_rise && state != SKIP) begin
                bit_cnt <= byte_done ? 3'd0 : cnt_sum[2:0];
                shifter <= shift_n;
            end
            if (byte_done && state == INSTR) begin
                addr       <= shift_n[4:0];
                bytes_left <= reg_size(shift_n[4:0]);
            end else if (byte_done && state == DATA) begin
                bytes_left <= bytes_left - 3'd1;
            end
            // transfer samples buffers before any same-cycle commit lands
            if (iou_rise) act_q <= buf_q;
            if (commit_req) begin
                last_addr <= commit_addr;
                case (commit_addr)
                    5'd0: csr <= shifter[7:0];
                    5'd1: begin
                        buf_q.vco <= shifter[23];
                        buf_q.pll <= shifter[22:18];
                    end
                    5'd3: begin
                        if (csr[6]) buf_q.dac[1:0] <= shifter[9:8];
                        if (csr[7]) buf_q.dac[3:2] <= shifter[9:8];
                    end
                    5'd4: begin
                        if (csr[6]) buf_q.ftw0 <= shifter;
                        if (csr[7]) buf_q.ftw1 <= shifter;
                    end
                    5'd6: begin
                        if (csr[6]) buf_q.asf0 <= shifter[9:0];
                        if (csr[7]) buf_q.asf1 <= shifter[9:0];
                        if (csr[6]) buf_q.asf_en[0] <= shifter[12];
                        if (csr[7]) buf_q.asf_en[1] <= shifter[12];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ftw_ch0    = act_q.ftw0;
    assign ftw_ch1    = act_q.ftw1;
    assign asf_ch0    = act_q.asf0;
    assign asf_ch1    = act_q.asf1;
    assign asf_en     = act_q.asf_en;
    assign dac_fscale = act_q.dac;
    assign vco_gain   = act_q.vco;
    assign pll_mult   = act_q.pll;
endmodule

// File: tb/tb_ad9958_spi_responder.sv
// Bench for ad9958_spi_responder: directed table, corner sequences and
// random frames checked against a register-level model.
module tb_ad9958_spi_responder;
    typedef logic [7:0] bq_t [$];

    typedef struct {
        bit          send;
        logic [7:0]  ins;
        logic [31:0] data;
        int          nb;
        bit          iou;
        logic [31:0] ftw0, ftw1;
        logic [9:0]  asf0, asf1;
        logic [1:0]  asfen;
        logic [3:0]  dac;
        logic        vco;
        logic [4:0]  pll;
        logic [7:0]  csr;
        int          str, err;
        logic [4:0]  la;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b0, cs_n = 1'b1, io_update = 1'b0, master_reset = 1'b0;
    logic [3:0]  sdio = 4'h0;
    logic [31:0] ftw_ch0, ftw_ch1;
    logic [9:0]  asf_ch0, asf_ch1;
    logic [1:0]  asf_en;
    logic [3:0]  dac_fscale;
    logic        vco_gain;
    logic [4:0]  pll_mult;
    logic [7:0]  csr;
    logic        write_strobe, frame_error;
    logic [4:0]  last_addr;

    always #5 clock = ~clock;

    ad9958_spi_responder dut (
        .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdio(sdio),
        .io_update(io_update), .master_reset(master_reset),
        .ftw_ch0(ftw_ch0), .ftw_ch1(ftw_ch1), .asf_ch0(asf_ch0), .asf_ch1(asf_ch1),
        .asf_en(asf_en), .dac_fscale(dac_fscale), .vco_gain(vco_gain),
        .pll_mult(pll_mult), .csr(csr), .write_strobe(write_strobe),
        .last_addr(last_addr), .frame_error(frame_error)
    );

    int n_cmp = 0, n_bad = 0;
    int str_cnt = 0, err_cnt = 0, str_base = 0, err_base = 0;

    always @(posedge clock) begin
        if (write_strobe === 1'b1) str_cnt++;
        if (frame_error === 1'b1) err_cnt++;
    end

    // register-level model
    logic [7:0]  m_csr;
    logic [31:0] m_fr1_b, m_fr1_a;
    logic [31:0] m_cfr_b[2], m_cfr_a[2], m_ftw_b[2], m_ftw_a[2];
    logic [31:0] m_acr_b[2], m_acr_a[2];
    int          m_str, m_err;

    function automatic void m_reset();
        m_csr = 8'hF0; m_fr1_b = 0; m_fr1_a = 0;
        for (int c = 0; c < 2; c++) begin
            m_cfr_b[c] = 0; m_cfr_a[c] = 0; m_ftw_b[c] = 0;
            m_ftw_a[c] = 0; m_acr_b[c] = 0; m_acr_a[c] = 0;
        end
        m_str = 0; m_err = 0;
    endfunction

    function automatic void m_iou();
        m_fr1_a = m_fr1_b;
        for (int c = 0; c < 2; c++) begin
            m_cfr_a[c] = m_cfr_b[c];
            m_ftw_a[c] = m_ftw_b[c];
            m_acr_a[c] = m_acr_b[c];
        end
    endfunction

    function automatic int m_size(int a);
        case (a)
            0: return 1;
            1: return 3;
            2: return 2;
            3: return 3;
            4: return 4;
            5: return 2;
            6: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic void m_write(int a, logic [31:0] v);
        if (a == 0) m_csr = v[7:0];
        else if (a == 1) m_fr1_b = v;
        for (int c = 0; c < 2; c++) begin
            if (m_csr[6+c] && a == 3) m_cfr_b[c] = v;
            if (m_csr[6+c] && a == 4) m_ftw_b[c] = v;
            if (m_csr[6+c] && a == 6) m_acr_b[c] = v;
        end
    endfunction

    function automatic void m_frame(bq_t b, int nfull, bit partial);
        int i, n;
        logic [31:0] v;
        logic [7:0] ins;
        if (m_csr[0]) begin m_err++; return; end
        i = 0;
        while (i < nfull) begin
            ins = b[i];
            n = m_size(int'(ins[4:0]));
            if (ins[7] || n == 0) begin m_err++; return; end
            if (i + 1 + n > nfull) begin m_err++; return; end
            v = 0;
            for (int k = 1; k <= n; k++) v = (v << 8) | 32'(b[i+k]);
            m_write(int'(ins[4:0]), v);
            m_str++;
            i += 1 + n;
        end
        if (partial) m_err++;
    endfunction

    function automatic bq_t mk(logic [7:0] ins, logic [31:0] d, int n);
        bq_t q;
        q.push_back(ins);
        for (int j = n - 1; j >= 0; j--) q.push_back(d[8*j+:8]);
        return q;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sclk_edge(input logic [3:0] d);
        sdio = d; wait_clk(5); sclk = 1'b1; wait_clk(5); sclk = 1'b0;
    endtask

    task automatic send(input bq_t b, input bit four, input int drop, input bit iou_end);
        int step = four ? 4 : 1;
        int total = b.size() * 8 / step - drop;
        int e = 0;
        logic [7:0] by;
        cs_n = 1'b0; wait_clk(6);
        for (int i = 0; i < b.size(); i++) begin
            for (int k = 8 - step; k >= 0; k -= step) begin
                if (e < total) begin
                    by = b[i];
                    sdio = four ? by[k+:4] : {3'b000, by[k]};
                    wait_clk(5); sclk = 1'b1;
                    if (iou_end && e == total - 1) begin
                        wait_clk(1); io_update = 1'b1; wait_clk(4);
                    end else wait_clk(5);
                    sclk = 1'b0;
                end
                e++;
            end
        end
        wait_clk(6); cs_n = 1'b1; io_update = 1'b0; wait_clk(12);
    endtask

    task automatic frame(input bq_t b, input int drop, input bit iou_end);
        bit four = (m_csr[2:1] == 2'b11);
        int step = four ? 4 : 1;
        int sent = b.size() * 8 - drop * step;
        send(b, four, drop, iou_end);
        if (iou_end) m_iou();
        m_frame(b, sent / 8, (sent % 8) != 0);
    endtask

    task automatic pulse_iou();
        io_update = 1'b1; wait_clk(4); io_update = 1'b0; wait_clk(8);
        m_iou();
    endtask

    task automatic check_all(input string tag);
        chk({tag, " ftw_ch0"}, ftw_ch0, m_ftw_a[0]);
        chk({tag, " ftw_ch1"}, ftw_ch1, m_ftw_a[1]);
        chk({tag, " asf_ch0"}, 32'(asf_ch0), 32'(m_acr_a[0][9:0]));
        chk({tag, " asf_ch1"}, 32'(asf_ch1), 32'(m_acr_a[1][9:0]));
        chk({tag, " asf_en"}, 32'(asf_en), 32'({m_acr_a[1][12], m_acr_a[0][12]}));
        chk({tag, " dac"}, 32'(dac_fscale), 32'({m_cfr_a[1][9:8], m_cfr_a[0][9:8]}));
        chk({tag, " vco"}, 32'(vco_gain), 32'(m_fr1_a[23]));
        chk({tag, " pll"}, 32'(pll_mult), 32'(m_fr1_a[22:18]));
        chk({tag, " csr"}, 32'(csr), 32'(m_csr));
        chk({tag, " strobes"}, 32'(str_cnt - str_base), 32'(m_str));
        chk({tag, " errors"}, 32'(err_cnt - err_base), 32'(m_err));
    endtask

    vec_t tbl[9];
    int   op;
    logic [31:0] d;
    logic [7:0]  ins;
    bq_t  q;

    initial begin
        tbl[0] = '{1'b1, 8'h04, 32'h12345678, 4, 1'b0, 32'h0, 32'h0, 10'h0, 10'h0,
                   2'b00, 4'h0, 1'b0, 5'd0, 8'hF0, 1, 0, 5'd4};
        tbl[1] = '{1'b0, 8'h00, 32'h0, 0, 1'b1, 32'h12345678, 32'h12345678, 10'h0,
                   10'h0, 2'b00, 4'h0, 1'b0, 5'd0, 8'hF0, 1, 0, 5'd4};
        tbl[2] = '{1'b1, 8'h01, 32'h009C0000, 3, 1'b1, 32'h12345678, 32'h12345678,
                   10'h0, 10'h0, 2'b00, 4'h0, 1'b1, 5'd7, 8'hF0, 2, 0, 5'd1};
        tbl[3] = '{1'b1, 8'h00, 32'h46, 1, 1'b0, 32'h12345678, 32'h12345678,
                   10'h0, 10'h0, 2'b00, 4'h0, 1'b1, 5'd7, 8'h46, 3, 0, 5'd0};
        tbl[4] = '{1'b1, 8'h06, 32'h000013FF, 3, 1'b1, 32'h12345678, 32'h12345678,
                   10'h3FF, 10'h0, 2'b01, 4'h0, 1'b1, 5'd7, 8'h46, 4, 0, 5'd6};
        tbl[5] = '{1'b1, 8'h00, 32'hF0, 1, 1'b0, 32'h12345678, 32'h12345678,
                   10'h3FF, 10'h0, 2'b01, 4'h0, 1'b1, 5'd7, 8'hF0, 5, 0, 5'd0};
        tbl[6] = '{1'b1, 8'h03, 32'h00000300, 3, 1'b1, 32'h12345678, 32'h12345678,
                   10'h3FF, 10'h0, 2'b01, 4'hF, 1'b1, 5'd7, 8'hF0, 6, 0, 5'd3};
        tbl[7] = '{1'b1, 8'h03, 32'h00000200, 3, 1'b1, 32'h12345678, 32'h12345678,
                   10'h3FF, 10'h0, 2'b01, 4'hA, 1'b1, 5'd7, 8'hF0, 7, 0, 5'd3};
        tbl[8] = '{1'b1, 8'h09, 32'h0, 1, 1'b0, 32'h12345678, 32'h12345678,
                   10'h3FF, 10'h0, 2'b01, 4'hA, 1'b1, 5'd7, 8'hF0, 7, 1, 5'd3};

        m_reset();
        wait_clk(4); reset = 1'b0; wait_clk(4);
        check_all("reset");
        chk("reset last_addr", 32'(last_addr), 32'd0);
        chk("reset write_strobe", 32'(write_strobe), 32'd0);
        chk("reset frame_error", 32'(frame_error), 32'd0);

        for (int r = 0; r < 9; r++) begin
            if (tbl[r].send) frame(mk(tbl[r].ins, tbl[r].data, tbl[r].nb), 0, 1'b0);
            if (tbl[r].iou) pulse_iou();
            chk($sformatf("t%0d ftw_ch0", r), ftw_ch0, tbl[r].ftw0);
            chk($sformatf("t%0d ftw_ch1", r), ftw_ch1, tbl[r].ftw1);
            chk($sformatf("t%0d asf_ch0", r), 32'(asf_ch0), 32'(tbl[r].asf0));
            chk($sformatf("t%0d asf_ch1", r), 32'(asf_ch1), 32'(tbl[r].asf1));
            chk($sformatf("t%0d asf_en", r), 32'(asf_en), 32'(tbl[r].asfen));
            chk($sformatf("t%0d dac", r), 32'(dac_fscale), 32'(tbl[r].dac));
            chk($sformatf("t%0d vco", r), 32'(vco_gain), 32'(tbl[r].vco));
            chk($sformatf("t%0d pll", r), 32'(pll_mult), 32'(tbl[r].pll));
            chk($sformatf("t%0d csr", r), 32'(csr), 32'(tbl[r].csr));
            chk($sformatf("t%0d strobes", r), 32'(str_cnt), 32'(tbl[r].str));
            chk($sformatf("t%0d errors", r), 32'(err_cnt), 32'(tbl[r].err));
            chk($sformatf("t%0d last_addr", r), 32'(last_addr), 32'(tbl[r].la));
        end

        q = '{8'h00, 8'h80, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        frame(q, 0, 1'b0);
        pulse_iou();
        check_all("stream");
        chk("stream ftw_ch1", ftw_ch1, 32'hDEADBEEF);
        chk("stream ftw_ch0", ftw_ch0, 32'h12345678);

        frame(mk(8'h04, 32'hAABBCCDD, 4), 16, 1'b0);
        check_all("partial reg");
        pulse_iou();
        check_all("partial reg iou");
        frame(mk(8'h84, 32'h0, 2), 0, 1'b0);
        check_all("read instr");
        frame(mk(8'h05, 32'h0, 0), 4, 1'b0);
        check_all("partial instr");
        frame(mk(8'h04, 32'h55667788, 4), 3, 1'b0);
        check_all("partial byte");

        frame(mk(8'h04, 32'h11223344, 4), 0, 1'b1);
        check_all("coincident");
        chk("coincident old ftw_ch1", ftw_ch1, 32'hDEADBEEF);
        pulse_iou();
        chk("coincident new ftw_ch1", ftw_ch1, 32'h11223344);
        check_all("coincident 2nd iou");

        frame(mk(8'h00, 32'hF1, 1), 0, 1'b0);
        frame(mk(8'h04, 32'h0BADF00D, 4), 0, 1'b0);
        check_all("lsb first");

        cs_n = 1'b0; wait_clk(6);
        for (int i = 0; i < 5; i++) sclk_edge(4'h1);
        master_reset = 1'b1; wait_clk(8); master_reset = 1'b0; wait_clk(8);
        cs_n = 1'b1; wait_clk(12);
        m_reset();
        str_base = str_cnt; err_base = err_cnt;
        check_all("master_reset");
        chk("master_reset csr", 32'(csr), 32'h000000F0);
        frame(mk(8'h04, 32'hCAFEF00D, 4), 0, 1'b0);
        pulse_iou();
        check_all("after master_reset");

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 9);
            d = $urandom;
            if (op == 9) begin
                pulse_iou();
            end else begin
                if (op <= 6) ins = {1'b0, 2'($urandom_range(0, 3)), 5'(op)};
                else if (op == 7) ins = {3'b000, 5'($urandom_range(7, 31))};
                else ins = {1'b1, 2'b00, 5'($urandom_range(0, 6))};
                if (op == 0) d = {24'h0, d[7:1], 1'b0};
                frame(mk(ins, d, (op <= 6) ? m_size(op) : 2), 0,
                      $urandom_range(0, 3) == 0);
                if (op <= 6) chk("random last_addr", 32'(last_addr), 32'(op));
            end
            check_all($sformatf("random %0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
